// File: rtl/axi_ahbl_bridge_if.sv
// Bus bundle for the AXI4-slave / AHB-Lite-master bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface axi_ahbl_bridge_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   s_awid;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [7:0]            s_awlen;
    logic [2:0]            s_awsize;
    logic [1:0]            s_awburst;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_wlast;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [ID_WIDTH-1:0]   s_bid;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ID_WIDTH-1:0]   s_arid;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [7:0]            s_arlen;
    logic [2:0]            s_arsize;
    logic [1:0]            s_arburst;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [ID_WIDTH-1:0]   s_rid;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rlast;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [ADDR_WIDTH-1:0] m_haddr;
    logic [2:0]            m_hburst;
    logic [2:0]            m_hsize;
    logic [1:0]            m_htrans;
    logic                  m_hwrite;
    logic [31:0]           m_hwdata;
    logic [31:0]           m_hrdata;
    logic                  m_hready;
    logic                  m_hresp;

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        output s_arready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready,
        output m_haddr, m_hburst, m_hsize, m_htrans, m_hwrite, m_hwdata,
        input  m_hrdata, m_hready, m_hresp
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        input  s_arready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready,
        input  m_haddr, m_hburst, m_hsize, m_htrans, m_hwrite, m_hwdata,
        output m_hrdata, m_hready, m_hresp
    );
endinterface

// File: rtl/axi_ahbl_bridge.sv
// AXI4 slave to AHB-Lite master bridge: every AXI beat becomes one
// non-pipelined AHB NONSEQ transfer, one transaction in flight at a time.
module axi_ahbl_bridge #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_ahbl_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WDAT, WADR, WPH, BRSP, RADR, RPH, RBEAT} state_t;

    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_NSEQ = 2'b10;
    localparam logic [1:0] R_OKAY  = 2'b00;
    localparam logic [1:0] R_SLV   = 2'b10;

    state_t                state_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q, rd_last_q;
    logic                  awready_q, arready_q, wready_q, bvalid_q, rvalid_q, rlast_q;
    logic [1:0]            bresp_q, rresp_q, htrans_q;
    logic [31:0]           rdata_q, hwdata_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [2:0]            hsize_q;
    logic                  hwrite_q;

    logic [ADDR_WIDTH-1:0] incr, wmask, addr_d;
    logic                  last_beat, bad_size, beat_err;

    always_comb begin
        incr  = ADDR_WIDTH'(1) << size_q;
        wmask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            2'b00:   addr_d = addr_q;
            2'b10:   addr_d = (addr_q & ~wmask) | ((addr_q + incr) & wmask);
            default: addr_d = addr_q + incr;
        endcase
    end

    assign last_beat = (cnt_q == len_q);
    assign bad_size  = (size_q > 3'd2);
    assign beat_err  = err_q | (!bad_size & bus.m_hresp);

    // Byte lanes and wlast carry no information here: hsize and awlen govern.
    logic unused_w;
    assign unused_w = ^{bus.s_wstrb, bus.s_wlast};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            rd_last_q <= 1'b1;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= R_OKAY;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= R_OKAY;
            rdata_q   <= '0;
            htrans_q  <= HT_IDLE;
            haddr_q   <= '0;
            hsize_q   <= '0;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A pending read only loses to a write if the read went last.
                    if (bus.s_awvalid && (!bus.s_arvalid || rd_last_q)) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        id_q      <= bus.s_awid;
                        addr_q    <= bus.s_awaddr;
                        len_q     <= bus.s_awlen;
                        size_q    <= bus.s_awsize;
                        burst_q   <= bus.s_awburst;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        rd_last_q <= 1'b0;
                        state_q   <= WDAT;
                    end else if (bus.s_arvalid) begin
                        arready_q <= 1'b1;
                        id_q      <= bus.s_arid;
                        addr_q    <= bus.s_araddr;
                        len_q     <= bus.s_arlen;
                        size_q    <= bus.s_arsize;
                        burst_q   <= bus.s_arburst;
                        cnt_q     <= '0;
                        rd_last_q <= 1'b1;
                        state_q   <= RADR;
                    end
                end
                WDAT: begin
                    awready_q <= 1'b0;
                    if (bus.s_wvalid && wready_q) begin
                        hwdata_q <= bus.s_wdata;
                        wready_q <= 1'b0;
                        state_q  <= WADR;
                    end
                end
                WADR: begin
                    if (bad_size) begin
                        err_q <= 1'b1;
                    end else begin
                        htrans_q <= HT_NSEQ;
                        hwrite_q <= 1'b1;
                        haddr_q  <= addr_q;
                        hsize_q  <= size_q;
                    end
                    state_q <= WPH;
                end
                WPH: begin
                    // NONSEQ still showing means the address phase has not been accepted.
                    if (htrans_q == HT_NSEQ) begin
                        if (bus.m_hready) htrans_q <= HT_IDLE;
                    end else if (bad_size || bus.m_hready) begin
                        err_q <= beat_err;
                        if (last_beat) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= beat_err ? R_SLV : R_OKAY;
                            state_q  <= BRSP;
                        end else begin
                            cnt_q    <= cnt_q + 8'd1;
                            addr_q   <= addr_d;
                            wready_q <= 1'b1;
                            state_q  <= WDAT;
                        end
                    end
                end
                BRSP: begin
                    if (bus.s_bready) begin
                        bvalid_q <= 1'b0;
                        err_q    <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RADR: begin
                    arready_q <= 1'b0;
                    if (bad_size) begin
                        rdata_q  <= '0;
                        rresp_q  <= R_SLV;
                        rvalid_q <= 1'b1;
                        rlast_q  <= last_beat;
                        state_q  <= RBEAT;
                    end else begin
                        htrans_q <= HT_NSEQ;
                        hwrite_q <= 1'b0;
                        haddr_q  <= addr_q;
                        hsize_q  <= size_q;
                        state_q  <= RPH;
                    end
                end
                RPH: begin
                    if (htrans_q == HT_NSEQ) begin
                        if (bus.m_hready) htrans_q <= HT_IDLE;
                    end else if (bus.m_hready) begin
                        rdata_q  <= bus.m_hrdata;
                        rresp_q  <= bus.m_hresp ? R_SLV : R_OKAY;
                        rvalid_q <= 1'b1;
                        rlast_q  <= last_beat;
                        state_q  <= RBEAT;
                    end
                end
                RBEAT: begin
                    if (bus.s_rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (last_beat) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            addr_q  <= addr_d;
                            state_q <= RADR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_awready = awready_q;
    assign bus.s_arready = arready_q;
    assign bus.s_wready  = wready_q;
    assign bus.s_bid     = id_q;
    assign bus.s_bresp   = bresp_q;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_rid     = id_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = rresp_q;
    assign bus.s_rlast   = rlast_q;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.m_haddr   = haddr_q;
    assign bus.m_hburst  = 3'b000;
    assign bus.m_hsize   = hsize_q;
    assign bus.m_htrans  = htrans_q;
    assign bus.m_hwrite  = hwrite_q;
    assign bus.m_hwdata  = hwdata_q;
endmodule

// File: tb/tb_axi_ahbl_bridge.sv
// Directed bench for axi_ahbl_bridge: AXI master driven from one initial block,
// a small AHB slave returning {haddr[15:0],16'hCAFE} with optional two-cycle error.
module tb_axi_ahbl_bridge;
    localparam int IDW = 4;
    localparam int AW  = 32;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    axi_ahbl_bridge_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW)) bus ();
    axi_ahbl_bridge #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

    int checks = 0;
    int errors = 0;

    // AHB slave model and transfer logs
    logic        tb_hready = 1'b1;
    logic [31:0] err_addr  = '1;
    logic        dph_v, dph_wr, dph_err, err_stage;
    logic [31:0] dph_addr;
    logic [35:0] alog[$];
    logic [31:0] wlog[$];
    logic [31:0] exp_a[4];

    assign bus.m_hready = tb_hready && !(dph_v && dph_err && !err_stage);
    assign bus.m_hresp  = dph_v && dph_err;
    assign bus.m_hrdata = dph_v ? {dph_addr[15:0], 16'hCAFE} : 32'h0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dph_v <= 1'b0; dph_wr <= 1'b0; dph_err <= 1'b0; err_stage <= 1'b0; dph_addr <= '0;
        end else begin
            if (dph_v && bus.m_hready) begin
                dph_v <= 1'b0;
                if (dph_wr) wlog.push_back(bus.m_hwdata);
            end else if (dph_v && dph_err) begin
                err_stage <= 1'b1;
            end
            if (bus.m_htrans == 2'b10 && bus.m_hready) begin
                dph_v     <= 1'b1;
                dph_addr  <= bus.m_haddr;
                dph_wr    <= bus.m_hwrite;
                dph_err   <= (bus.m_haddr == err_addr);
                err_stage <= 1'b0;
                alog.push_back({bus.m_hsize, bus.m_hwrite, bus.m_haddr});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_set(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt);
        bus.s_awid = id; bus.s_awaddr = a; bus.s_awlen = len; bus.s_awsize = sz;
        bus.s_awburst = bt; bus.s_awvalid = 1'b1;
    endtask

    task automatic ar_set(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt);
        bus.s_arid = id; bus.s_araddr = a; bus.s_arlen = len; bus.s_arsize = sz;
        bus.s_arburst = bt; bus.s_arvalid = 1'b1;
    endtask

    // Waits for an address handshake and checks which channel won it.
    task automatic addr_hs(input bit exp_w, input string tag);
        bit seen = 1'b0;
        bit got_w = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.s_awready || bus.s_arready) begin
                seen  = 1'b1;
                got_w = bus.s_awready;
                @(negedge aclk);
                if (got_w) bus.s_awvalid = 1'b0; else bus.s_arvalid = 1'b0;
            end else @(negedge aclk);
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_dir"}, 64'(got_w), 64'(exp_w));
    endtask

    task automatic w_beat(input logic [31:0] d);
        bit seen = 1'b0;
        bus.s_wdata = d; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.s_wready) begin
                seen = 1'b1;
                @(negedge aclk);
                bus.s_wvalid = 1'b0;
            end else @(negedge aclk);
        end
        chk("w_hs_seen", 64'(seen), 64'd1);
    endtask

    task automatic b_get(input logic [3:0] id, input logic [1:0] resp, input string tag);
        bit seen = 1'b0;
        bus.s_bready = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.s_bvalid) begin
                seen = 1'b1;
                chk({tag, "_bid"}, 64'(bus.s_bid), 64'(id));
                chk({tag, "_bresp"}, 64'(bus.s_bresp), 64'(resp));
                @(negedge aclk);
                chk({tag, "_bdrop"}, 64'(bus.s_bvalid), 64'd0);
            end else @(negedge aclk);
        end
        bus.s_bready = 1'b0;
        chk({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic r_get(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                         input logic last, input string tag);
        bit seen = 1'b0;
        bus.s_rready = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.s_rvalid) begin
                seen = 1'b1;
                chk({tag, "_rid"}, 64'(bus.s_rid), 64'(id));
                chk({tag, "_rdata"}, 64'(bus.s_rdata), 64'(d));
                chk({tag, "_rresp"}, 64'(bus.s_rresp), 64'(resp));
                chk({tag, "_rlast"}, 64'(bus.s_rlast), 64'(last));
                @(negedge aclk);
            end else @(negedge aclk);
        end
        bus.s_rready = 1'b0;
        chk({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'({bus.s_awready, bus.s_arready, bus.s_wready}), 64'd0);
        chk({tag, "_valid"}, 64'({bus.s_bvalid, bus.s_rvalid}), 64'd0);
        chk({tag, "_htrans"}, 64'(bus.m_htrans), 64'd0);
        chk({tag, "_haddr"}, 64'(bus.m_haddr), 64'd0);
        chk({tag, "_hctl"}, 64'({bus.m_hsize, bus.m_hwrite, bus.m_hburst}), 64'd0);
        chk({tag, "_hwdata"}, 64'(bus.m_hwdata), 64'd0);
        chk({tag, "_resp"}, 64'({bus.s_bresp, bus.s_rresp}), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.s_rdata), 64'd0);
    endtask

    initial begin
        bit rv;
        bus.s_awvalid = 0; bus.s_arvalid = 0; bus.s_wvalid = 0; bus.s_bready = 0; bus.s_rready = 0;
        bus.s_awid = 0; bus.s_awaddr = 0; bus.s_awlen = 0; bus.s_awsize = 0; bus.s_awburst = 0;
        bus.s_arid = 0; bus.s_araddr = 0; bus.s_arlen = 0; bus.s_arsize = 0; bus.s_arburst = 0;
        bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wlast = 0;
        #1 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk_reset_outputs("rst");
        aresetn = 1'b1;
        @(negedge aclk);

        // Single write
        aw_set(4'h3, 32'h10, 8'd0, 3'd2, 2'b01);
        addr_hs(1'b1, "t1_aw");
        w_beat(32'hDEADBEEF);
        b_get(4'h3, 2'b00, "t1_b");
        chk("t1_ntr", 64'(alog.size()), 64'd1);
        chk("t1_addr", 64'(alog[0]), 64'({3'd2, 1'b1, 32'h10}));
        chk("t1_wdata", 64'(wlog[0]), 64'hDEADBEEF);
        alog.delete(); wlog.delete();

        // INCR read, first beat timed cycle by cycle
        ar_set(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
        @(negedge aclk); chk("t2_c0_arready", 64'(bus.s_arready), 64'd1);
        @(negedge aclk); bus.s_arvalid = 1'b0;
        chk("t2_c1_htrans", 64'(bus.m_htrans), 64'h2);
        chk("t2_c1_haddr", 64'(bus.m_haddr), 64'h100);
        chk("t2_c1_hsize", 64'(bus.m_hsize), 64'd2);
        @(negedge aclk); chk("t2_c2_htrans", 64'(bus.m_htrans), 64'h0);
        chk("t2_c2_rvalid", 64'(bus.s_rvalid), 64'd0);
        @(negedge aclk); chk("t2_c3_rvalid", 64'(bus.s_rvalid), 64'd1);
        r_get(4'h5, 32'h0100CAFE, 2'b00, 1'b0, "t2_r0");
        r_get(4'h5, 32'h0104CAFE, 2'b00, 1'b0, "t2_r1");
        r_get(4'h5, 32'h0108CAFE, 2'b00, 1'b0, "t2_r2");
        r_get(4'h5, 32'h010CCAFE, 2'b00, 1'b1, "t2_r3");
        chk("t2_ntr", 64'(alog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t2_haddr", 64'(alog[i]), 64'({3'd2, 1'b0, 32'h100 + 32'(4 * i)}));
        alog.delete();

        // WRAP read
        exp_a[0] = 32'h108; exp_a[1] = 32'h10C; exp_a[2] = 32'h100; exp_a[3] = 32'h104;
        ar_set(4'h6, 32'h108, 8'd3, 3'd2, 2'b10);
        addr_hs(1'b0, "t3_ar");
        for (int i = 0; i < 4; i++)
            r_get(4'h6, {exp_a[i][15:0], 16'hCAFE}, 2'b00, (i == 3), "t3_r");
        for (int i = 0; i < 4; i++)
            chk("t3_haddr", 64'(alog[i]), 64'({3'd2, 1'b0, exp_a[i]}));
        alog.delete();

        // 3-beat write with a two-cycle error on the 2nd beat
        err_addr = 32'h204;
        aw_set(4'h7, 32'h200, 8'd2, 3'd2, 2'b01);
        addr_hs(1'b1, "t4_aw");
        w_beat(32'h11111111);
        w_beat(32'h22222222);
        w_beat(32'h33333333);
        b_get(4'h7, 2'b10, "t4_b");
        chk("t4_ntr", 64'(alog.size()), 64'd3);
        chk("t4_a2", 64'(alog[2]), 64'({3'd2, 1'b1, 32'h208}));
        chk("t4_w2", 64'(wlog[2]), 64'h33333333);
        err_addr = '1;
        alog.delete(); wlog.delete();

        // Both valid after a write: read wins
        aw_set(4'h8, 32'h400, 8'd0, 3'd2, 2'b01);
        ar_set(4'h9, 32'h500, 8'd0, 3'd2, 2'b01);
        addr_hs(1'b0, "t5_arb");
        r_get(4'h9, 32'h0500CAFE, 2'b00, 1'b1, "t5_r");
        addr_hs(1'b1, "t5_aw");
        w_beat(32'hA5A5A5A5);
        b_get(4'h8, 2'b00, "t5_b");
        alog.delete(); wlog.delete();

        // Unsupported size: no AHB transfer, error responses
        aw_set(4'h1, 32'h600, 8'd0, 3'd3, 2'b01);
        addr_hs(1'b1, "t6_aw");
        w_beat(32'h12345678);
        b_get(4'h1, 2'b10, "t6_b");
        ar_set(4'h2, 32'h600, 8'd0, 3'd3, 2'b01);
        addr_hs(1'b0, "t6_ar");
        r_get(4'h2, 32'h0, 2'b10, 1'b1, "t6_r");
        chk("t6_noahb", 64'(alog.size()), 64'd0);

        // Reset while the read is outstanding
        ar_set(4'h3, 32'h300, 8'd0, 3'd2, 2'b01);
        addr_hs(1'b0, "t7_ar");
        tb_hready = 1'b0;
        @(negedge aclk);
        chk("t7_inflight", 64'(bus.m_htrans), 64'h2);
        aresetn = 1'b0;
        #1 chk_reset_outputs("t7_rst");
        tb_hready = 1'b1;
        @(negedge aclk); aresetn = 1'b1;
        rv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            rv |= bus.s_rvalid;
        end
        chk("t7_norvalid", 64'(rv), 64'd0);
        ar_set(4'h4, 32'h304, 8'd0, 3'd2, 2'b01);
        addr_hs(1'b0, "t7_ar2");
        r_get(4'h4, 32'h0304CAFE, 2'b00, 1'b1, "t7_r2");

        // Fresh reset, then simultaneous AW/AR twice with an AHB stall
        aresetn = 1'b0;
        @(negedge aclk); aresetn = 1'b1;
        @(negedge aclk);
        alog.delete(); wlog.delete();
        aw_set(4'hA, 32'h700, 8'd0, 3'd2, 2'b01);
        ar_set(4'hB, 32'h800, 8'd0, 3'd2, 2'b01);
        addr_hs(1'b1, "t8_arb1");
        tb_hready = 1'b0;
        w_beat(32'hCAFEF00D);
        @(negedge aclk);
        for (int i = 0; i < 5; i++) begin
            chk("t8_stall_haddr", 64'(bus.m_haddr), 64'h700);
            chk("t8_stall_htrans", 64'(bus.m_htrans), 64'h2);
            @(negedge aclk);
        end
        tb_hready = 1'b1;
        b_get(4'hA, 2'b00, "t8_b1");
        addr_hs(1'b0, "t8_ar1");
        r_get(4'hB, 32'h0800CAFE, 2'b00, 1'b1, "t8_r1");
        aw_set(4'hC, 32'h710, 8'd0, 3'd2, 2'b01);
        ar_set(4'hD, 32'h810, 8'd0, 3'd2, 2'b01);
        addr_hs(1'b1, "t8_arb2");
        w_beat(32'h0BADF00D);
        b_get(4'hC, 2'b00, "t8_b2");
        addr_hs(1'b0, "t8_ar2");
        r_get(4'hD, 32'h0810CAFE, 2'b00, 1'b1, "t8_r2");
        chk("t8_ntr", 64'(alog.size()), 64'd4);
        chk("t8_a0", 64'(alog[0]), 64'({3'd2, 1'b1, 32'h700}));
        chk("t8_w0", 64'(wlog[0]), 64'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
